// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
// State encoding, default sizes and requester indices.
package mem_arbiter_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 12;

   localparam int REQ_VID = 0;
   localparam int REQ_CPU = 1;
   localparam int REQ_GPU = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_WAIT,
      ST_RD_DONE
   } st_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory side signals of the arbiter.
// slave: arbiter view; master: requesters plus memory.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF
);

   logic [NREQ-1:0]    rq_read;
   logic [NREQ*AW-1:0] rq_read_idx;
   logic [7:0]         rq_read_byte;
   logic [NREQ-1:0]    rq_read_ack;
   logic [NREQ-1:0]    rq_write;
   logic [NREQ*AW-1:0] rq_write_idx;
   logic [NREQ*8-1:0]  rq_write_byte;
   logic [NREQ-1:0]    rq_write_ack;

   logic               mem_read;
   logic [AW-1:0]      mem_read_idx;
   logic [7:0]         mem_read_byte;
   logic               mem_read_ack;
   logic               mem_write;
   logic [AW-1:0]      mem_write_idx;
   logic [7:0]         mem_write_byte;

   modport slave (
      input  rq_read, rq_read_idx,
      input  rq_write, rq_write_idx, rq_write_byte,
      input  mem_read_byte, mem_read_ack,
      output rq_read_byte, rq_read_ack, rq_write_ack,
      output mem_read, mem_read_idx,
      output mem_write, mem_write_idx, mem_write_byte
   );

   modport master (
      output rq_read, rq_read_idx,
      output rq_write, rq_write_idx, rq_write_byte,
      output mem_read_byte, mem_read_ack,
      input  rq_read_byte, rq_read_ack, rq_write_ack,
      input  mem_read, mem_read_idx,
      input  mem_write, mem_write_idx, mem_write_byte
   );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// One-hot winner selection for the memory arbiter.
// Searches upward from ptr_i+1 with wrap; first request wins.
module arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o
);

   logic found;
   int   k;

   // Scan requesters starting just after the pointer
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(ptr_i) + 1 + i) % NREQ;
         if (!found && req_i[k]) begin
            gnt_o[k] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for video, CPU and GPU requesters.
// Define ARB_RR_EN for round-robin; otherwise lowest index wins.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus_if
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   st_e             state_q, state_d;
   logic [IW-1:0]   win_q, win_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      rdata_q, rdata_d;
   logic [NREQ-1:0] req_any, gnt, win_oh;
   logic [IW-1:0]   gnt_idx, ptr;
   logic            gnt_wr;

   assign req_any = bus_if.rq_read | bus_if.rq_write;

`ifdef ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;

   // Last granted requester drops to lowest priority
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_IDLE && |req_any)
         ptr_d = gnt_idx;
   end

   // Rotation pointer; starts so requester 0 is searched first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= IW'(NREQ - 1);
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   assign ptr = IW'(NREQ - 1);
`endif

   arb_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req_i (req_any),
      .ptr_i (ptr),
      .gnt_o (gnt)
   );

   // Encode the one-hot grant as a requester index
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) gnt_idx = IW'(i);
   end

   // A winner with a pending write is served write-first
   assign gnt_wr = |(gnt & bus_if.rq_write);

   // Next state and transaction latches
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_any) begin
               win_d = gnt_idx;
               if (gnt_wr) begin
                  state_d = ST_WR;
                  addr_d  = bus_if.rq_write_idx[int'(gnt_idx)*AW +: AW];
                  wdata_d = bus_if.rq_write_byte[int'(gnt_idx)*8 +: 8];
               end else begin
                  state_d = ST_RD_WAIT;
                  addr_d  = bus_if.rq_read_idx[int'(gnt_idx)*AW +: AW];
               end
            end
         end
         ST_WR: state_d = ST_IDLE;
         ST_RD_WAIT: begin
            if (bus_if.mem_read_ack) begin
               rdata_d = bus_if.mem_read_byte;
               state_d = ST_RD_DONE;
            end
         end
         ST_RD_DONE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // One-hot view of the latched winner
   always_comb begin
      win_oh        = '0;
      win_oh[win_q] = 1'b1;
   end

   // Outputs decoded from registered state only
   always_comb begin
      bus_if.mem_write      = (state_q == ST_WR);
      bus_if.mem_read       = (state_q == ST_RD_WAIT);
      bus_if.mem_write_idx  = addr_q;
      bus_if.mem_read_idx   = addr_q;
      bus_if.mem_write_byte = wdata_q;
      bus_if.rq_read_byte   = rdata_q;
      bus_if.rq_write_ack   = (state_q == ST_WR) ? win_oh : '0;
      bus_if.rq_read_ack    = (state_q == ST_RD_DONE) ? win_oh : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus corner sequences.
// Holds a byte-wide memory model and a variable-latency read responder.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NREQ = 3;
   localparam int AW   = 12;

   typedef struct {
      int         req;
      bit         wr;
      logic [11:0] addr;
      logic [7:0] wb;
      int         lat;
      logic [2:0] exp_ack;
      logic [7:0] exp_b;
   } vec_t;

   typedef struct {
      int         cyc;
      bit         wr;
      logic [2:0] ack;
      logic [7:0] b;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

   mem_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         lat = 1;
   int         rcnt = 0;
   bit         auto_mem = 1'b1;
   bit         hold_vid = 1'b0;
   logic [7:0] mem [4096];
   ev_t        log_q[$];
   vec_t       vecs[9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      logic [2:0] acks;
      @(negedge clk);
      cyc++;
      if (bus.mem_write) mem[bus.mem_write_idx] = bus.mem_write_byte;
      if (bus.mem_read_ack) begin
         bus.mem_read_ack = 1'b0;
      end else if (auto_mem && bus.mem_read) begin
         if (rcnt >= lat - 1) begin
            bus.mem_read_ack  = 1'b1;
            bus.mem_read_byte = mem[bus.mem_read_idx];
            rcnt = 0;
         end else begin
            rcnt++;
         end
      end else begin
         rcnt = 0;
      end
      acks = bus.rq_read_ack | bus.rq_write_ack;
      chk("ack_onehot", 32'($countones(acks) <= 1), 32'd1);
      if (|bus.rq_write_ack)
         log_q.push_back('{cyc, 1'b1, bus.rq_write_ack, 8'h00});
      if (|bus.rq_read_ack)
         log_q.push_back('{cyc, 1'b0, bus.rq_read_ack, bus.rq_read_byte});
      bus.rq_write = bus.rq_write & ~bus.rq_write_ack;
      if (hold_vid)
         bus.rq_read = bus.rq_read & ~(bus.rq_read_ack & 3'b110);
      else
         bus.rq_read = bus.rq_read & ~bus.rq_read_ack;
   endtask

   task automatic wait_events(input int need, input int budget,
                              input string nm);
      for (int n = 0; n < budget && log_q.size() < need; n++) tick();
      if (log_q.size() < need)
         chk({nm, "_timeout"}, 32'(log_q.size()), 32'(need));
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int    start;
      string nm;
      nm = $sformatf("vec%0d", id);
      log_q.delete();
      start = cyc;
      lat = v.lat;
      if (v.wr) begin
         bus.rq_write_idx[v.req*AW +: AW] = v.addr;
         bus.rq_write_byte[v.req*8 +: 8] = v.wb;
         bus.rq_write[v.req] = 1'b1;
      end else begin
         bus.rq_read_idx[v.req*AW +: AW] = v.addr;
         bus.rq_read[v.req] = 1'b1;
      end
      for (int n = 0; n < 20 && log_q.size() == 0; n++) begin
         tick();
         if (bus.mem_read)
            chk({nm, "_rd_idx"}, 32'(bus.mem_read_idx), 32'(v.addr));
         if (|bus.rq_write_ack) begin
            chk({nm, "_mem_write"}, 32'(bus.mem_write), 32'd1);
            chk({nm, "_wr_idx"}, 32'(bus.mem_write_idx), 32'(v.addr));
            chk({nm, "_wr_byte"}, 32'(bus.mem_write_byte), 32'(v.wb));
         end
      end
      if (log_q.size() == 0) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({nm, "_ack"}, 32'(log_q[0].ack), 32'(v.exp_ack));
      chk({nm, "_kind"}, 32'(log_q[0].wr), 32'(v.wr));
      chk({nm, "_latency"}, 32'(log_q[0].cyc - start),
          32'(v.wr ? 1 : v.lat + 1));
      if (!v.wr)
         chk({nm, "_rd_byte"}, 32'(log_q[0].b), 32'(v.exp_b));
      tick();
      chk({nm, "_pulse_off"},
          32'({bus.rq_read_ack, bus.rq_write_ack}), 32'd0);
      chk({nm, "_strobes_off"},
          32'({bus.mem_read, bus.mem_write}), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int         ord[3];
      logic [7:0] byte_of[3];
      bit         cpu_in2;
      bit         cpu_in6;
      bit         found;

      vecs[0] = '{REQ_CPU, 1'b1, 12'h100, 8'hFF, 1, 3'b010, 8'h00};
      vecs[1] = '{REQ_GPU, 1'b1, 12'h042, 8'hFF, 1, 3'b100, 8'h00};
      vecs[2] = '{REQ_GPU, 1'b0, 12'h042, 8'h00, 3, 3'b100, 8'hFF};
      vecs[3] = '{REQ_VID, 1'b1, 12'hABC, 8'h5A, 1, 3'b001, 8'h00};
      vecs[4] = '{REQ_VID, 1'b0, 12'hABC, 8'h00, 1, 3'b001, 8'h5A};
      vecs[5] = '{REQ_CPU, 1'b0, 12'h100, 8'h00, 2, 3'b010, 8'hFF};
      vecs[6] = '{REQ_CPU, 1'b0, 12'h7FF, 8'h00, 1, 3'b010, 8'h00};
      vecs[7] = '{REQ_GPU, 1'b1, 12'hFFF, 8'h81, 1, 3'b100, 8'h00};
      vecs[8] = '{REQ_VID, 1'b0, 12'hFFF, 8'h00, 4, 3'b001, 8'h81};

      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      bus.rq_read = '0;
      bus.rq_read_idx = '0;
      bus.rq_write = '0;
      bus.rq_write_idx = '0;
      bus.rq_write_byte = '0;
      bus.mem_read_ack = 1'b0;
      bus.mem_read_byte = 8'h00;

      tick();
      tick();
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_acks", 32'({bus.rq_read_ack, bus.rq_write_ack}), 32'd0);
      chk("rst_rd_byte", 32'(bus.rq_read_byte), 32'd0);
      chk("rst_mem_idx", 32'({bus.mem_read_idx, bus.mem_write_idx}), 32'd0);
      chk("rst_mem_byte", 32'(bus.mem_write_byte), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // all three read together; a video write first makes it "last"
      run_vec('{REQ_VID, 1'b1, 12'hABC, 8'h5A, 1, 3'b001, 8'h00}, 9);
      log_q.delete();
      lat = 1;
      bus.rq_read_idx[REQ_VID*AW +: AW] = 12'hABC;
      bus.rq_read_idx[REQ_CPU*AW +: AW] = 12'h100;
      bus.rq_read_idx[REQ_GPU*AW +: AW] = 12'hFFF;
      bus.rq_read = 3'b111;
      byte_of = '{8'h5A, 8'hFF, 8'h81};
`ifdef ARB_RR_EN
      ord = '{1, 2, 0};
`else
      ord = '{0, 1, 2};
`endif
      wait_events(3, 40, "all3");
      for (int k = 0; k < 3 && k < log_q.size(); k++) begin
         chk($sformatf("all3_order%0d", k), 32'(log_q[k].ack),
             32'(1 << ord[k]));
         chk($sformatf("all3_byte%0d", k), 32'(log_q[k].b),
             32'(byte_of[ord[k]]));
      end
      tick();

      // same requester reads and writes one address in one cycle
      log_q.delete();
      bus.rq_write_idx[REQ_GPU*AW +: AW] = 12'h108;
      bus.rq_write_byte[REQ_GPU*8 +: 8] = 8'hC3;
      bus.rq_read_idx[REQ_GPU*AW +: AW] = 12'h108;
      bus.rq_write[REQ_GPU] = 1'b1;
      bus.rq_read[REQ_GPU] = 1'b1;
      wait_events(2, 30, "rw_same");
      if (log_q.size() >= 2) begin
         chk("rw_first_is_write", 32'(log_q[0].wr), 32'd1);
         chk("rw_first_ack", 32'(log_q[0].ack), 32'b100);
         chk("rw_second_is_read", 32'(log_q[1].wr), 32'd0);
         chk("rw_read_byte", 32'(log_q[1].b), 32'hC3);
      end
      tick();

      // request dropped while the read is outstanding still completes
      log_q.delete();
      lat = 3;
      bus.rq_read_idx[REQ_CPU*AW +: AW] = 12'h042;
      bus.rq_read[REQ_CPU] = 1'b1;
      for (int n = 0; n < 10 && !bus.mem_read; n++) tick();
      chk("drop_mem_read_seen", 32'(bus.mem_read), 32'd1);
      bus.rq_read[REQ_CPU] = 1'b0;
      wait_events(1, 20, "drop");
      if (log_q.size() >= 1) begin
         chk("drop_ack", 32'(log_q[0].ack), 32'b010);
         chk("drop_byte", 32'(log_q[0].b), 32'hFF);
      end
      tick();

      // reset while waiting on memory, then a stray late ack
      log_q.delete();
      auto_mem = 1'b0;
      bus.rq_read_idx[REQ_CPU*AW +: AW] = 12'h100;
      bus.rq_read[REQ_CPU] = 1'b1;
      for (int n = 0; n < 10 && !bus.mem_read; n++) tick();
      chk("rstmid_mem_read", 32'(bus.mem_read), 32'd1);
      tick();
      tick();
      rst_n = 1'b0;
      bus.rq_read = '0;
      tick();
      chk("rstmid_mem_read_low", 32'(bus.mem_read), 32'd0);
      chk("rstmid_acks", 32'({bus.rq_read_ack, bus.rq_write_ack}), 32'd0);
      chk("rstmid_rd_byte", 32'(bus.rq_read_byte), 32'd0);
      chk("rstmid_rd_idx", 32'(bus.mem_read_idx), 32'd0);
      rst_n = 1'b1;
      tick();
      bus.mem_read_byte = 8'h77;
      bus.mem_read_ack = 1'b1;
      tick();
      tick();
      tick();
      chk("stray_no_ack", 32'(log_q.size()), 32'd0);
      chk("stray_rd_byte", 32'(bus.rq_read_byte), 32'd0);
      chk("stray_mem_read", 32'(bus.mem_read), 32'd0);
      auto_mem = 1'b1;
      run_vec(vecs[4], 10);

      // video hammers reads while the CPU waits
      log_q.delete();
      lat = 1;
      bus.rq_read_idx[REQ_VID*AW +: AW] = 12'hABC;
      bus.rq_read_idx[REQ_CPU*AW +: AW] = 12'h100;
      hold_vid = 1'b1;
      bus.rq_read = 3'b011;
      wait_events(6, 60, "hammer");
      cpu_in2 = 1'b0;
      cpu_in6 = 1'b0;
      for (int k = 0; k < log_q.size() && k < 6; k++) begin
         if (log_q[k].ack[REQ_CPU]) begin
            cpu_in6 = 1'b1;
            if (k < 2) cpu_in2 = 1'b1;
         end
      end
`ifdef ARB_RR_EN
      chk("rr_cpu_within2", 32'(cpu_in2), 32'd1);
`else
      chk("fixed_cpu_starved", 32'(cpu_in6), 32'd0);
`endif
      hold_vid = 1'b0;
      bus.rq_read[REQ_VID] = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
         tick();
         foreach (log_q[k]) if (log_q[k].ack[REQ_CPU]) found = 1'b1;
      end
      chk("cpu_served_eventually", 32'(found), 32'd1);
      tick();
      tick();
      chk("final_idle", 32'({bus.mem_read, bus.mem_write}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters; index 0 = video scanout, 1 = CPU, 2 = GPU.
REQ-002 Parameter AW, default 12, memory address width.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rq_read  input  NREQ  per-requester read request, held until matching ack.
REQ-006 rq_read_idx  input  NREQ*AW  packed read addresses, slice i belongs to requester i.
REQ-007 rq_read_byte  output  8  read data, shared by all requesters, valid when any rq_read_ack bit is 1.
REQ-008 rq_read_ack  output  NREQ  one-cycle read completion pulse per requester.
REQ-009 rq_write  input  NREQ  per-requester write request, held until matching ack.
REQ-010 rq_write_idx  input  NREQ*AW  packed write addresses.
REQ-011 rq_write_byte  input  NREQ*8  packed write data.
REQ-012 rq_write_ack  output  NREQ  one-cycle write completion pulse per requester.
REQ-013 mem_read  output  1  read strobe to memory, held until mem_read_ack.
REQ-014 mem_read_idx  output  AW  read address to memory.
REQ-015 mem_read_byte  input  8  memory read data, valid with mem_read_ack.
REQ-016 mem_read_ack  input  1  memory read completion, one cycle, arbitrary latency >= 1.
REQ-017 mem_write  output  1  one-cycle write strobe to memory.
REQ-018 mem_write_idx  output  AW  write address; mem_write_byte  output  8  write data.

Function
REQ-019 FSM states IDLE, WR, RD_WAIT, RD_DONE; exactly one memory transaction in flight.
REQ-020 IDLE: if any rq_read/rq_write bit set, select one winner per REQ-030/031 and latch its index and address/data into registers.
REQ-021 Winner with both read and write pending SHALL have its write served first.
REQ-022 Write grant: next cycle state WR, mem_write=1, mem_write_idx/byte = latched values, rq_write_ack[winner]=1, all for exactly one cycle; then IDLE.
REQ-023 Read grant: next cycle state RD_WAIT, mem_read=1, mem_read_idx = latched address, held stable until mem_read_ack.
REQ-024 RD_WAIT with mem_read_ack=1: capture mem_read_byte; next cycle state RD_DONE, mem_read=0, rq_read_ack[winner]=1, rq_read_byte = captured byte; then IDLE.
REQ-025 Latency: write ack 1 cycle after IDLE decision; read ack 1 cycle after mem_read_ack.
REQ-026 Requesters drop their request on the edge where they sample ack; a request still high in IDLE after ack is a new request.
REQ-027 Request deasserted mid-transaction SHALL NOT abort it; ack still issued.
REQ-028 mem_read_ack outside RD_WAIT ignored; rq_read_byte holds last value between acks.
REQ-029 At most one bit of rq_read_ack|rq_write_ack set in any cycle; all mem outputs 0 when not in WR/RD_WAIT, except idx/byte may hold.

Configuration
REQ-030 ARB_RR_EN defined: round-robin; the requester granted last has lowest priority at next IDLE decision, search ascending index from last+1 with wrap.
REQ-031 ARB_RR_EN undefined: fixed priority, lowest index wins (scanout > CPU > GPU).

Reset
REQ-032 rst_n low: state IDLE, all acks, mem_read, mem_write 0, rq_read_byte 0, mem idx/byte registers 0, round-robin pointer to NREQ-1 (requester 0 first); in-flight transaction abandoned without ack.
REQ-033 Reset release mid-flight: stray mem_read_ack arriving in IDLE ignored.

Structure
REQ-034 Shared package: state enum, NREQ/AW defaults, requester index constants REQ_VID/REQ_CPU/REQ_GPU.
REQ-035 One sub-module arb_pick: combinational one-hot winner selection from request vector and rotation pointer.

Verification
REQ-036 Single CPU write 0x100<=0xFF -> mem_write one cycle idx 0x100 byte 0xFF, rq_write_ack=3'b010 same cycle.
REQ-037 GPU read 0x042, memory ack latency 3 -> rq_read_ack=3'b100 one cycle after mem_read_ack, rq_read_byte 0xFF.
REQ-038 All three read simultaneously, fixed priority -> grant order 0,1,2; round-robin with last=0 -> order 1,2,0.
REQ-039 GPU read and write 0x108 same cycle -> write acked first, read returns newly written byte 0xC3.
REQ-040 rst_n low during RD_WAIT, then late mem_read_ack -> no rq_read_ack, state IDLE, next request served normally.
REQ-041 Scanout requesting continuously, fixed priority, CPU pending -> CPU starved (documented); round-robin -> CPU served within 2 grants.
